symfir_bitstream: RTL

SYMFIR_BITSTREAM -- requirements
Module: symfir_bitstream

---
 rtl/symfir_bitstream.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/symfir_bitstream.sv
// ---------------------------------------------------------------------------
// symfir_bitstream
//
// Symmetric FIR filter over a 1-bit sample stream (bit 1 -> +1, bit 0 -> -1).
// Incoming bits are written to a circular capture buffer. Capture continues
// while a computation runs. A start request copies that buffer, rotated so
// the oldest bit comes first, into a calc buffer. The filter then runs one
// symmetric tap pair per cycle, rounds and shifts the sum, reduces it to
// OUT_W bits and emits it with a one-cycle push strobe.
//
// Optional feature macro: SYMFIR_SAT_EN
//   defined   -> the rounded result is clamped to the OUT_W signed range
//   undefined -> the rounded result wraps to its low OUT_W bits
//
// Parameters
//   DEPTH   tap count (even, >= 4)
//   COEF_W  signed coefficient width
//   OUT_W   signed output width
//   SHIFT   arithmetic right shift applied with round-half-up (0..15)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   bit_in     sample bit
//   bit_valid  capture bit_in this cycle
//   filter     start request, honoured only in IDLE
//   coef_wr    coefficient write strobe, honoured only in IDLE
//   coef_addr  coefficient index (pair index k)
//   coef_data  signed coefficient value
//   dout       signed result, held between pushes
//   push       one-cycle strobe marking dout valid
//   busy       high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module symfir_bitstream #(
    parameter int DEPTH  = 512,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    input  logic                          filter,
    input  logic                          coef_wr,
    input  logic [$clog2(DEPTH/2)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]      coef_data,
    output logic signed [OUT_W-1:0]       dout,
    output logic                          push,
    output logic                          busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH/2);
    localparam int AW = COEF_W + $clog2(DEPTH) + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CALC  = 3'd2;
    localparam logic [2:0] ST_ROUND = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

    localparam logic [PW:0]   DEPTH_L = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] K_LAST  = CW'(DEPTH/2 - 1);
    // (1 << SHIFT) >> 1 yields 2^(SHIFT-1), and 0 when SHIFT is 0
    localparam logic signed [AW:0] RND_V = (AW+1)'(((64'sd1 <<< SHIFT) >>> 1));
`ifdef SYMFIR_SAT_EN
    localparam logic signed [AW:0] MAX_V = (AW+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [AW:0] MIN_V = -MAX_V - (AW+1)'(1);
`endif

    logic [2:0]                 state_r;
    logic [2:0]                 state_nx_s;
    logic [DEPTH-1:0]           cap_r;
    logic [DEPTH-1:0]           calc_r;
    logic [DEPTH-1:0]           rot_s;
    logic [PW-1:0]              wr_ptr_r;
    logic [CW-1:0]              k_r;
    logic signed [COEF_W-1:0]   coef_r [DEPTH/2];
    logic signed [AW-1:0]       acc_r;
    logic signed [AW-1:0]       term_s;
    logic signed [AW-1:0]       c_ext_s;
    logic [PW-1:0]              lo_idx_s;
    logic [PW-1:0]              hi_idx_s;
    logic signed [AW:0]         acc_ext_s;
    logic signed [AW:0]         rnd_s;
    logic signed [OUT_W-1:0]    red_s;
    logic signed [OUT_W-1:0]    res_r;
    logic signed [OUT_W-1:0]    dout_r;
    logic                       push_r;
    logic                       busy_r;
    logic                       start_s;

    assign start_s = (state_r == ST_IDLE) && filter;
    assign dout    = dout_r;
    assign push    = push_r;
    assign busy    = busy_r;

    // Next-state logic for the IDLE/LOAD/CALC/ROUND/OUT sequencer
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (filter) state_nx_s = ST_LOAD;
                else        state_nx_s = ST_IDLE;
            end
            ST_LOAD: state_nx_s = ST_CALC;
            ST_CALC: begin
                if (k_r == K_LAST) state_nx_s = ST_ROUND;
                else               state_nx_s = ST_CALC;
            end
            ST_ROUND: state_nx_s = ST_OUT;
            ST_OUT:   state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // Rotated view of the capture buffer: element i is the bit i places after the write pointer
    always_comb begin
        rot_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW:0] idx;
            idx = {1'b0, wr_ptr_r} + (PW+1)'(i);
            if (idx >= DEPTH_L) idx = idx - DEPTH_L;
            else                idx = idx;
            rot_s[i] = cap_r[idx[PW-1:0]];
        end
    end

    // Symmetric pair term: (s(x[k]) + s(x[DEPTH-1-k])) * c[k], pre-add is -2, 0 or +2
    always_comb begin
        lo_idx_s = PW'(k_r);
        hi_idx_s = PTR_MAX - PW'(k_r);
        c_ext_s  = AW'(coef_r[k_r]);
        case ({calc_r[lo_idx_s], calc_r[hi_idx_s]})
            2'b11:   term_s = c_ext_s <<< 1;
            2'b00:   term_s = -(c_ext_s <<< 1);
            default: term_s = '0;
        endcase
    end

    // Round-half-up, arithmetic shift, then reduce to OUT_W bits
    always_comb begin
        acc_ext_s = (AW+1)'(acc_r);
        rnd_s     = (acc_ext_s + RND_V) >>> SHIFT;
`ifdef SYMFIR_SAT_EN
        if (rnd_s > MAX_V)      red_s = MAX_V[OUT_W-1:0];
        else if (rnd_s < MIN_V) red_s = MIN_V[OUT_W-1:0];
        else                    red_s = OUT_W'(rnd_s);
`else
        red_s = OUT_W'(rnd_s);
`endif
    end

    // Capture buffer and write pointer; runs in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_r    <= '0;
            wr_ptr_r <= '0;
        end else if (bit_valid) begin
            cap_r[wr_ptr_r] <= bit_in;
            wr_ptr_r        <= (wr_ptr_r == PTR_MAX) ? '0 : wr_ptr_r + PW'(1);
        end
    end

    // Coefficient store, writable only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH/2; i++) coef_r[i] <= '0;
        end else if (coef_wr && (state_r == ST_IDLE)) begin
            coef_r[coef_addr] <= coef_data;
        end
    end

    // FSM state, calc buffer snapshot, pair counter and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            calc_r  <= '0;
            k_r     <= '0;
            acc_r   <= '0;
            res_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            if (start_s) calc_r <= rot_s;
            case (state_r)
                ST_LOAD: begin
                    acc_r <= '0;
                    k_r   <= '0;
                end
                ST_CALC: begin
                    acc_r <= acc_r + term_s;
                    k_r   <= k_r + CW'(1);
                end
                ST_ROUND: res_r <= red_s;
                default: ;
            endcase
        end
    end

    // Registered outputs: result, push strobe and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r <= '0;
            push_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            push_r <= (state_r == ST_OUT);
            busy_r <= (state_nx_s != ST_IDLE);
            if (state_r == ST_OUT) dout_r <= res_r;
        end
    end

endmodule
